edge_event_sched: RTL

- Detects per-input event conditions (any-change, rising edge, falling edge) on NUM_EV signals and queues each as a pending request.
- Grants pending requests one at a time, round-robin, to a single shared toggle register through a valid/ready handshake.
- Gives diagnostic benches one synthesizable arbiter for mixed-sensitivity event lists that drive a shared target.

---
 rtl/edge_event_sched_if.sv | 11 +
 rtl/edge_event_sched.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/edge_event_sched_if.sv
// Grant handshake between the event scheduler and its consumer.
interface edge_event_sched_if #(
   parameter int ID_W = 2
);
   logic            gnt_valid;
   logic            gnt_ready;
   logic [ID_W-1:0] gnt_id;

   modport master (output gnt_valid, output gnt_id, input gnt_ready);
   modport slave  (input gnt_valid, input gnt_id, output gnt_ready);
endinterface

// File: rtl/edge_event_sched.sv
// Per-input edge/change detection feeding a round-robin scheduler that grants
// one pending request at a time and toggles a shared register on acceptance.
module edge_event_sched #(
   parameter int NUM_EV = 3,
   parameter int ID_W   = 2,
   parameter int CNT_W  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_EV-1:0]     ev_in,
   input  logic [2*NUM_EV-1:0]   ev_mode,
   edge_event_sched_if.master    gnt,
   output logic                  d_out,
   output logic [NUM_EV-1:0]     pending,
   output logic [CNT_W-1:0]      drop_cnt
);

   localparam int IDX_W = (NUM_EV > 1) ? $clog2(NUM_EV) : 1;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [NUM_EV-1:0] ev_q;
   logic [NUM_EV-1:0] evt;
   logic [NUM_EV-1:0] drop;
   logic [NUM_EV-1:0] pending_nxt;
   logic [ID_W-1:0]   gnt_id_q;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   rr_nxt;
   logic [ID_W-1:0]   sel_idx;
   logic              sel_found;
   logic              handshake;
   logic [CNT_W-1:0]  cnt_nxt;

   assign handshake = gnt.gnt_valid & gnt.gnt_ready;

   always_comb begin
      evt = '0;
      for (int i = 0; i < NUM_EV; i++) begin
         case (ev_mode[2*i +: 2])
            2'b01:   evt[i] = ev_in[i] & ~ev_q[i];
            2'b10:   evt[i] = ~ev_in[i] & ev_q[i];
            2'b11:   evt[i] = ev_in[i] ^ ev_q[i];
            default: evt[i] = 1'b0;
         endcase
      end
   end

   // A new event wins over a same-cycle clear; a disabled input is flushed
   // unless it is the grant currently on offer.
   always_comb begin
      logic clr;
      pending_nxt = pending;
      drop        = '0;
      clr         = 1'b0;
      for (int i = 0; i < NUM_EV; i++) begin
         clr = handshake && (int'(gnt_id_q) == i);
         if (evt[i]) begin
            pending_nxt[i] = 1'b1;
            drop[i]        = pending[i] & ~clr;
         end else if (clr) begin
            pending_nxt[i] = 1'b0;
         end else if (ev_mode[2*i +: 2] == 2'b00 &&
                      !(gnt.gnt_valid && int'(gnt_id_q) == i)) begin
            pending_nxt[i] = 1'b0;
         end
      end
   end

   always_comb begin
      cnt_nxt = drop_cnt;
      for (int i = 0; i < NUM_EV; i++) begin
         if (drop[i] && cnt_nxt != {CNT_W{1'b1}}) begin
            cnt_nxt = cnt_nxt + CNT_W'(1);
         end
      end
   end

   // Scan downward so the set bit closest to rr_ptr is the last one written.
   always_comb begin
      logic [IDX_W-1:0] idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      idx       = '0;
      for (int off = NUM_EV - 1; off >= 0; off--) begin
         idx = IDX_W'((int'(rr_ptr) + off) % NUM_EV);
         if (pending[idx]) begin
            sel_found = 1'b1;
            sel_idx   = ID_W'(idx);
         end
      end
   end

   assign rr_nxt = (int'(gnt_id_q) == NUM_EV - 1) ? '0 : gnt_id_q + ID_W'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ev_q     <= '0;
         pending  <= '0;
         drop_cnt <= '0;
      end else begin
         ev_q     <= ev_in;
         pending  <= pending_nxt;
         drop_cnt <= cnt_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sel_found) state_nxt = ISSUE;
         ISSUE:   if (gnt.gnt_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt.gnt_valid = (state == ISSUE);
      gnt.gnt_id    = gnt_id_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         gnt_id_q <= '0;
         rr_ptr   <= '0;
         d_out    <= 1'b0;
      end else begin
         if (state == IDLE && sel_found) begin
            gnt_id_q <= sel_idx;
         end
         if (handshake) begin
            d_out  <= ~d_out;
            rr_ptr <= rr_nxt;
         end
      end
   end

endmodule
